paddle_motion_scheduler: RTL and testbench

Per-frame paddle motion sequencer. It sits between the two per-player button controllers and the ball/render logic. It captures each player's 2-bit paddle command between frame ticks and time-shares one position/speed update unit between P1 and P2 on every frame tick. It outputs clamped, accelerated paddle positions and a one-cycle done strobe.

---
 rtl/paddle_motion_scheduler_pkg.sv | 37 +++
 rtl/paddle_motion_scheduler_if.sv | 24 ++
 rtl/paddle_motion_scheduler_step.sv | 49 ++++
 rtl/paddle_motion_scheduler.sv | 105 ++++++++++
 tb/tb_paddle_motion_scheduler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/paddle_motion_scheduler_pkg.sv
// Shared constants, command/state encodings and the command decode helper
// for the paddle motion scheduler.
package pong_pkg;
    localparam int POS_W        = 10;
    localparam int FIELD_MAX    = 640;
    localparam int PADDLE_W     = 64;
    localparam int SPEED_MIN    = 2;
    localparam int SPEED_MAX    = 8;
    localparam int ACCEL_FRAMES = 4;
    localparam int SPD_W        = 4;
    localparam int HOLD_W       = 3;

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(FIELD_MAX - PADDLE_W);
    localparam logic [POS_W-1:0] POS_RST = POS_W'((FIELD_MAX - PADDLE_W) / 2);

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_LEFT  = 2'b01,
        CMD_RIGHT = 2'b10
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD_P1 = 2'd1,
        UPD_P2 = 2'd2,
        DONE   = 2'd3
    } state_t;

    // 11 is treated the same as 00: no movement request
    function automatic cmd_t cmd_dir(input logic [1:0] c);
        case (c)
            2'b01:   return CMD_LEFT;
            2'b10:   return CMD_RIGHT;
            default: return CMD_NONE;
        endcase
    endfunction
endpackage

// File: rtl/paddle_motion_scheduler_if.sv
// Frame/command inputs and paddle/status outputs of the scheduler.
interface paddle_motion_scheduler_if;
    import pong_pkg::*;

    logic             frame_tick;
    logic             freeze;
    logic [1:0]       p1_cmd;
    logic [1:0]       p2_cmd;
    logic [POS_W-1:0] p1_pos;
    logic [POS_W-1:0] p2_pos;
    logic             busy;
    logic             update_done;
    logic             tick_overrun;

    modport master (
        output frame_tick, freeze, p1_cmd, p2_cmd,
        input  p1_pos, p2_pos, busy, update_done, tick_overrun
    );

    modport slave (
        input  frame_tick, freeze, p1_cmd, p2_cmd,
        output p1_pos, p2_pos, busy, update_done, tick_overrun
    );
endinterface

// File: rtl/paddle_motion_scheduler_step.sv
// Combinational per-paddle step: acceleration bookkeeping plus clamped motion.
module paddle_step
    import pong_pkg::*;
(
    input  logic [POS_W-1:0]  pos_i,
    input  logic [SPD_W-1:0]  speed_i,
    input  logic [HOLD_W-1:0] hold_i,
    input  cmd_t              prev_dir_i,
    input  cmd_t              dir_i,
    output logic [POS_W-1:0]  pos_o,
    output logic [SPD_W-1:0]  speed_o,
    output logic [HOLD_W-1:0] hold_o,
    output cmd_t              dir_o
);
    localparam logic [SPD_W-1:0]  SPD_MIN   = SPD_W'(SPEED_MIN);
    localparam logic [SPD_W-1:0]  SPD_MAX   = SPD_W'(SPEED_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_FRAMES - 1);

    logic signed [POS_W:0] sum;

    always_comb begin
        speed_o = SPD_MIN;
        hold_o  = '0;
        pos_o   = pos_i;
        dir_o   = dir_i;
        sum     = '0;
        if (dir_i != CMD_NONE && dir_i == prev_dir_i) begin
            if (hold_i == HOLD_LAST) begin
                speed_o = (speed_i >= SPD_MAX) ? SPD_MAX : speed_i + SPD_W'(1);
            end else begin
                hold_o  = hold_i + HOLD_W'(1);
                speed_o = speed_i;
            end
        end
        // Motion uses the speed just computed for this frame
        if (dir_i != CMD_NONE) begin
            if (dir_i == CMD_RIGHT)
                sum = $signed({1'b0, pos_i}) + $signed({{(POS_W+1-SPD_W){1'b0}}, speed_o});
            else
                sum = $signed({1'b0, pos_i}) - $signed({{(POS_W+1-SPD_W){1'b0}}, speed_o});
            if (sum < 0)
                pos_o = '0;
            else if (sum > $signed({1'b0, POS_MAX}))
                pos_o = POS_MAX;
            else
                pos_o = sum[POS_W-1:0];
        end
    end
endmodule

// File: rtl/paddle_motion_scheduler.sv
// Latches paddle commands between frame ticks and time-shares one paddle_step
// unit between P1 and P2 on each accepted tick.
module paddle_motion_scheduler
    import pong_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    paddle_motion_scheduler_if.slave  bus
);
    state_t state_q, state_d;
    logic   snap, sel;

    logic [1:0][1:0]        lat_q, lat_d, work_q, prev_q, cmd_in;
    logic [1:0][POS_W-1:0]  pos_q;
    logic [1:0][SPD_W-1:0]  spd_q;
    logic [1:0][HOLD_W-1:0] hold_q;
    logic                   busy_q, done_q, ovr_q;

    logic [POS_W-1:0]  st_pos;
    logic [SPD_W-1:0]  st_spd;
    logic [HOLD_W-1:0] st_hold;
    cmd_t              st_dir;

    assign cmd_in[0] = cmd_dir(bus.p1_cmd);
    assign cmd_in[1] = cmd_dir(bus.p2_cmd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        snap    = 1'b0;
        case (state_q)
            IDLE: if (bus.frame_tick) begin
                state_d = UPD_P1;
                snap    = 1'b1;
            end
            UPD_P1:  state_d = UPD_P2;
            UPD_P2:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Idle 00/11 cycles must not erase a pending command
    always_comb begin
        lat_d = lat_q;
        for (int i = 0; i < 2; i++) begin
            if (snap)                      lat_d[i] = CMD_NONE;
            else if (cmd_in[i] != CMD_NONE) lat_d[i] = cmd_in[i];
        end
    end

    assign sel = (state_q == UPD_P2);

    paddle_step u_step (
        .pos_i      (pos_q[sel]),
        .speed_i    (spd_q[sel]),
        .hold_i     (hold_q[sel]),
        .prev_dir_i (cmd_t'(prev_q[sel])),
        .dir_i      (cmd_t'(work_q[sel])),
        .pos_o      (st_pos),
        .speed_o    (st_spd),
        .hold_o     (st_hold),
        .dir_o      (st_dir)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_q  <= '0;
            work_q <= '0;
            prev_q <= '0;
            pos_q  <= {2{POS_RST}};
            spd_q  <= {2{SPD_W'(SPEED_MIN)}};
            hold_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            lat_q <= lat_d;
            if (snap) begin
                for (int i = 0; i < 2; i++)
                    work_q[i] <= bus.freeze ? CMD_NONE :
                                 (cmd_in[i] != CMD_NONE) ? cmd_in[i] : lat_q[i];
            end
            if (state_q == UPD_P1 || state_q == UPD_P2) begin
                pos_q[sel]  <= st_pos;
                spd_q[sel]  <= st_spd;
                hold_q[sel] <= st_hold;
                prev_q[sel] <= st_dir;
            end
            busy_q <= (state_d == UPD_P1) || (state_d == UPD_P2);
            done_q <= (state_d == DONE);
            ovr_q  <= bus.frame_tick && (state_q != IDLE);
        end
    end

    assign bus.p1_pos       = pos_q[0];
    assign bus.p2_pos       = pos_q[1];
    assign bus.busy         = busy_q;
    assign bus.update_done  = done_q;
    assign bus.tick_overrun = ovr_q;
endmodule

// File: tb/tb_paddle_motion_scheduler.sv
// Randomized and directed bench for paddle_motion_scheduler against a
// frame-level reference model.
module tb_paddle_motion_scheduler;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    paddle_motion_scheduler_if bus();

    paddle_motion_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: dirs 0 none, 1 left, 2 right. age = cycles since accepted tick.
    int m_pos[2], m_old[2], m_spd[2], m_hold[2], m_prev[2], m_lat[2];
    int age;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int dir_of(input int c);
        return (c == 1) ? 1 : (c == 2) ? 2 : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 288; m_old[i] = 288; m_spd[i] = 2;
            m_hold[i] = 0;  m_prev[i] = 0;  m_lat[i] = 0;
        end
        age = 99;
    endtask

    task automatic m_step(input int i, input int d);
        if (d == 0) begin
            m_spd[i] = 2; m_hold[i] = 0;
        end else if (d == m_prev[i]) begin
            m_hold[i]++;
            if (m_hold[i] == 4) begin
                m_hold[i] = 0;
                m_spd[i]  = (m_spd[i] + 1 > 8) ? 8 : m_spd[i] + 1;
            end
        end else begin
            m_spd[i] = 2; m_hold[i] = 0;
        end
        if (d == 2)      m_pos[i] = (m_pos[i] + m_spd[i] > 576) ? 576 : m_pos[i] + m_spd[i];
        else if (d == 1) m_pos[i] = (m_pos[i] - m_spd[i] < 0)   ? 0   : m_pos[i] - m_spd[i];
        m_prev[i] = d;
    endtask

    task automatic chk_outs(input int exp_ovr);
        chk("busy", int'(bus.busy), (age == 1 || age == 2) ? 1 : 0);
        chk("update_done", int'(bus.update_done), (age == 3) ? 1 : 0);
        chk("tick_overrun", int'(bus.tick_overrun), exp_ovr);
        chk("p1_pos", int'(bus.p1_pos), (age >= 2) ? m_pos[0] : m_old[0]);
        chk("p2_pos", int'(bus.p2_pos), (age >= 3) ? m_pos[1] : m_old[1]);
    endtask

    // Apply inputs for one cycle (from a negedge), then check at the next negedge
    task automatic cyc(input int c1, input int c2, input bit tk, input bit fz);
        bit acc;
        int cin[2];
        int d[2];
        bus.p1_cmd     = 2'(c1);
        bus.p2_cmd     = 2'(c2);
        bus.frame_tick = tk;
        bus.freeze     = fz;
        cin[0] = dir_of(c1);
        cin[1] = dir_of(c2);
        acc = tk && (age >= 4);
        for (int i = 0; i < 2; i++) begin
            d[i] = 0;
            if (acc) begin
                d[i] = fz ? 0 : (cin[i] != 0) ? cin[i] : m_lat[i];
                m_lat[i] = 0;
            end else if (cin[i] != 0) begin
                m_lat[i] = cin[i];
            end
        end
        if (acc) begin
            for (int i = 0; i < 2; i++) begin
                m_old[i] = m_pos[i];
                m_step(i, d[i]);
            end
        end
        @(negedge clk);
        age = acc ? 1 : (age < 99 ? age + 1 : 99);
        chk_outs((tk && !acc) ? 1 : 0);
    endtask

    task automatic idle(input int n, input int c1, input int c2);
        for (int k = 0; k < n; k++) cyc(c1, c2, 1'b0, 1'b0);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.freeze     = 1'b0;
        bus.p1_cmd     = 2'b00;
        bus.p2_cmd     = 2'b00;
        m_reset();
        repeat (2) @(negedge clk);
        chk_outs(0);
        reset = 1'b1;
        idle(2, 0, 0);

        // Tick with no commands
        cyc(0, 0, 1, 0);
        idle(4, 0, 0);

        // Alternating 01/00 must survive to the tick; latch cleared afterwards
        for (int k = 0; k < 10; k++) cyc((k % 2 == 0) ? 1 : 0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("p1_alt_286", int'(bus.p1_pos), 286);
        chk("p2_alt_288", int'(bus.p2_pos), 288);
        idle(3, 0, 0);
        cyc(0, 0, 1, 0);
        idle(4, 0, 0);
        chk("p1_latch_clear", int'(bus.p1_pos), 286);

        // Reset during UPD_P2
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        #1;
        m_reset();
        chk("rst_async_p1", int'(bus.p1_pos), 288);
        chk("rst_async_busy", int'(bus.busy), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", int'(bus.update_done), 0);
        end
        reset = 1'b1;
        idle(1, 0, 0);
        cyc(2, 0, 1, 0);
        idle(4, 0, 0);

        // Held right on P2 for 12 frames: 2,2,2,2,3,3,3,3,4,4,4,4
        m_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(1, 0, 0);
        for (int f = 0; f < 12; f++) begin
            cyc(0, 2, 1, 0);
            idle(3, 0, 2);
        end
        idle(1, 0, 0);
        chk("p2_accel_324", int'(bus.p2_pos), 324);

        // Drive both to the walls
        for (int f = 0; f < 60; f++) begin
            cyc(1, 2, 1, 0);
            idle(3, 1, 2);
        end
        idle(1, 0, 0);
        chk("p1_clamp_0", int'(bus.p1_pos), 0);
        chk("p2_clamp_576", int'(bus.p2_pos), 576);

        // Overrun: ticks at T+2 and T+3 ignored, T+4 accepted
        cyc(2, 1, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        idle(4, 0, 0);

        // Freeze with active commands
        for (int f = 0; f < 6; f++) begin
            cyc(2, 1, 1, 0);
            idle(3, 2, 1);
        end
        cyc(2, 1, 1, 1);
        idle(4, 0, 0);
        cyc(2, 1, 1, 0);
        idle(4, 0, 0);

        // Random traffic
        for (int k = 0; k < 600; k++)
            cyc($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        idle(4, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
